// File: rtl/nic8_pkg.sv
// Shared types and constants for the nic8 output-port UART.
package nic8_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/nic8_sync_fifo.sv
// Single-clock FIFO with wrapping pointers and an explicit occupancy counter.
module nic8_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [AW:0]      count_q, count_d;
  logic             doPush, doPop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rdPtr_q];

  // A full FIFO still accepts a write when the same edge frees a slot.
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + AW'(1);
    if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
    case ({doPush, doPop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= din;
  end

endmodule

// File: rtl/nic8_out_uart.sv
// Buffers CPU OUT bytes and shifts them out LSB-first as 8N1 serial frames.
module nic8_out_uart
  import nic8_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   do_out,
  input  logic [7:0]             out_data,
  output logic                   tx,
  output logic                   busy,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(UART_DATA_BITS);

  tx_state_t                 state_q, state_d;
  logic [BW-1:0]             baud_q, baud_d;
  logic [IW-1:0]             bitIdx_q, bitIdx_d;
  logic [UART_DATA_BITS-1:0] sh_q, sh_d;
  logic                      tx_q, tx_d;
  logic                      overflow_q, overflow_d;
  logic                      fifoPop, fifoFull, fifoEmpty, baudDone;
  logic [7:0]                fifoDout;

  nic8_sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (do_out),
    .pop   (fifoPop),
    .din   (out_data),
    .dout  (fifoDout),
    .count (count),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  assign baudDone = (baud_q == BW'(CLKS_PER_BIT - 1));

  // tx_d is the line level for the state being entered, so tx stays registered.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bitIdx_d = bitIdx_q;
    sh_d     = sh_q;
    tx_d     = tx_q;
    fifoPop  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = UART_IDLE_LEVEL;
        if (!fifoEmpty) begin
          fifoPop  = 1'b1;
          sh_d     = fifoDout;
          baud_d   = '0;
          bitIdx_d = '0;
          state_d  = START;
          tx_d     = ~UART_IDLE_LEVEL;
        end
      end
      START: begin
        tx_d   = ~UART_IDLE_LEVEL;
        baud_d = baud_q + BW'(1);
        if (baudDone) begin
          baud_d  = '0;
          state_d = DATA;
          tx_d    = sh_q[0];
        end
      end
      DATA: begin
        tx_d   = sh_q[0];
        baud_d = baud_q + BW'(1);
        if (baudDone) begin
          baud_d = '0;
          if (bitIdx_q == IW'(UART_DATA_BITS - 1)) begin
            state_d = STOP;
            tx_d    = UART_IDLE_LEVEL;
          end else begin
            sh_d     = sh_q >> 1;
            bitIdx_d = bitIdx_q + IW'(1);
            tx_d     = sh_q[1];
          end
        end
      end
      STOP: begin
        tx_d   = UART_IDLE_LEVEL;
        baud_d = baud_q + BW'(1);
        if (baudDone) begin
          baud_d  = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = UART_IDLE_LEVEL;
      end
    endcase
  end

  assign overflow_d = overflow_q | (do_out & fifoFull & ~fifoPop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bitIdx_q   <= '0;
      sh_q       <= '0;
      tx_q       <= UART_IDLE_LEVEL;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bitIdx_q   <= bitIdx_d;
      sh_q       <= sh_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx       = tx_q;
  assign full     = fifoFull;
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE) || !fifoEmpty;

endmodule

// File: tb/tb_nic8_out_uart.sv
// Directed bench for nic8_out_uart: per-cycle frame tables plus a tx decoder scoreboard.
module tb_nic8_out_uart;

  localparam int DEPTH = 4;
  localparam int CPB   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       do_out = 1'b0;
  logic [7:0] out_data = 8'h00;
  logic       tx, busy, full, overflow;
  logic [2:0] count;

  int nCompared = 0;
  int nMismatched = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } frameVec_t;

  frameVec_t  vecs[5];
  logic [7:0] expQ[$];
  bit         monEn = 1'b0;

  nic8_out_uart #(
    .DEPTH        (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .do_out   (do_out),
    .out_data (out_data),
    .tx       (tx),
    .busy     (busy),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [7:0] d);
    do_out   = wr;
    out_data = d;
    tick();
    do_out   = 1'b0;
  endtask

  task automatic doReset();
    monEn = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_tx", tx, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_overflow", overflow, 0);
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      tick();
      n++;
    end
    checkOutput({name, "_busy_drop"}, busy, 0);
    repeat (45) tick();
    checkOutput({name, "_all_frames_seen"}, expQ.size(), 0);
    expQ.delete();
    monEn = 1'b0;
  endtask

  // Decodes tx frames relative to the first low sample and scores them against expQ.
  initial begin : monitor
    logic [7:0] shr;
    logic [7:0] e;
    int off;
    bit inFrame;
    shr = '0;
    off = 0;
    inFrame = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!monEn) begin
        inFrame = 1'b0;
      end else if (!inFrame) begin
        if (tx === 1'b0) begin
          inFrame = 1'b1;
          off = 0;
        end
      end else begin
        off++;
        if (off >= 6 && off <= 34 && ((off - 6) % 4) == 0) shr[(off - 6) / 4] = tx;
        if (off == 38) begin
          inFrame = 1'b0;
          checkOutput("mon_stop_bit", tx, 1);
          if (expQ.size() == 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL mon_extra_frame: got %0h, expected no frame", shr);
          end else begin
            e = expQ.pop_front();
            checkOutput("mon_byte", shr, e);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] burst[6];
    logic [2:0] burstCount[6];
    logic [7:0] d;

    vecs[0] = '{data: 8'h41, frame: 10'b1010000010};
    vecs[1] = '{data: 8'h00, frame: 10'b1000000000};
    vecs[2] = '{data: 8'hFF, frame: 10'b1111111110};
    vecs[3] = '{data: 8'hA5, frame: 10'b1101001010};
    vecs[4] = '{data: 8'h3C, frame: 10'b1001111000};
    burst      = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    burstCount = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};

    doReset();

    $display("[TB] single frames, per-cycle tx check");
    for (int v = 0; v < 5; v++) begin
      applyStimulus(1'b1, vecs[v].data);
      checkOutput("t1_count_after_write", count, 1);
      checkOutput("t1_busy_after_write", busy, 1);
      applyStimulus(1'b0, 8'h00);
      checkOutput("t1_count_after_pop", count, 0);
      for (int k = 0; k < 10 * CPB; k++) begin
        checkOutput($sformatf("t1_v%0d_tx_k%0d", v, k), tx, vecs[v].frame[k / CPB]);
        tick();
      end
      checkOutput("t1_busy_done", busy, 0);
      checkOutput("t1_tx_idle", tx, 1);
    end

    $display("[TB] back-to-back frames");
    applyStimulus(1'b1, 8'h00);
    checkOutput("t2_count_first", count, 1);
    applyStimulus(1'b1, 8'hFF);
    checkOutput("t2_count_push_pop", count, 1);
    for (int k = 0; k < 10 * CPB; k++) begin
      checkOutput($sformatf("t2_f0_tx_k%0d", k), tx, vecs[1].frame[k / CPB]);
      tick();
    end
    checkOutput("t2_gap_tx", tx, 1);
    checkOutput("t2_gap_count", count, 1);
    checkOutput("t2_gap_busy", busy, 1);
    tick();
    checkOutput("t2_count_second_pop", count, 0);
    for (int k = 0; k < 10 * CPB; k++) begin
      checkOutput($sformatf("t2_f1_tx_k%0d", k), tx, vecs[2].frame[k / CPB]);
      tick();
    end
    checkOutput("t2_busy_done", busy, 0);

    $display("[TB] overflow burst");
    monEn = 1'b1;
    for (int i = 0; i < 5; i++) expQ.push_back(burst[i]);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, burst[i]);
      checkOutput($sformatf("t3_count_w%0d", i), count, burstCount[i]);
      checkOutput($sformatf("t3_overflow_w%0d", i), overflow, (i == 5) ? 1 : 0);
    end
    checkOutput("t3_full", full, 1);
    drain("t3");
    checkOutput("t3_overflow_sticky", overflow, 1);

    $display("[TB] write on the popping edge while full");
    doReset();
    monEn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expQ.push_back(8'h21 + 8'(i));
      applyStimulus(1'b1, 8'h21 + 8'(i));
    end
    checkOutput("t4_count_full", count, 4);
    repeat (37) applyStimulus(1'b0, 8'h00);
    checkOutput("t4_count_before_pop", count, 4);
    checkOutput("t4_full_before_pop", full, 1);
    expQ.push_back(8'h26);
    applyStimulus(1'b1, 8'h26);
    checkOutput("t4_count_after_pop_write", count, 4);
    checkOutput("t4_full_after_pop_write", full, 1);
    checkOutput("t4_overflow_clear", overflow, 0);
    drain("t4");

    $display("[TB] reset in the middle of a data bit");
    doReset();
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'h5A);
    checkOutput("t5_count_queued", count, 1);
    repeat (17) tick();
    checkOutput("t5_tx_data_bit3", tx, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_tx_abort", tx, 1);
    checkOutput("t5_count_abort", count, 0);
    checkOutput("t5_busy_abort", busy, 0);
    #2;
    rst_n = 1'b1;
    tick();
    checkOutput("t5_tx_after_release", tx, 1);
    monEn = 1'b1;
    expQ.push_back(8'hA5);
    applyStimulus(1'b1, 8'hA5);
    drain("t5");
    checkOutput("t5_overflow", overflow, 0);

    $display("[TB] random writes under scoreboard");
    doReset();
    monEn = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (full === 1'b0 && $urandom_range(0, 2) == 0) begin
        d = 8'($urandom);
        expQ.push_back(d);
        applyStimulus(1'b1, d);
      end else begin
        applyStimulus(1'b0, 8'h00);
      end
    end
    drain("t6");
    checkOutput("t6_overflow", overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
